prog_cntr_timer: RTL and testbench
==================================

PROG_CNTR_TIMER -- requirements
Module: prog_cntr_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8; counter, limit and count output width (2..32).
REQ-002 SHALL have parameter PRESCALE_W, default 4; prescale field width (1..16).
REQ-003 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port rst_n_2  input  1  reset rst_n_2, asynchronous, active-low; clock clk.
REQ-005 SHALL have port en  input  1  synchronous run enable, level.
REQ-006 SHALL have port mode  input  2  00 up-wrap, 01 one-shot, 10 down-reload, 11 triangle.
REQ-007 SHALL have port limit  input  WIDTH  terminal value, captured on load.
REQ-008 SHALL have port load  input  1  single-cycle strobe capturing limit into the shadow register.
REQ-009 SHALL have port prescale  input  PRESCALE_W  tick divider; tick every prescale+1 enabled cycles.
REQ-010 SHALL have port count  output  WIDTH  current count, registered.
REQ-011 SHALL have port done  output  1  one-cycle terminal pulse, registered.
REQ-012 SHALL have port busy  output  1  high while enabled and not halted in one-shot.
REQ-013 SHALL have port dir  output  1  1 = counting down, registered.

Function
REQ-014 SHALL hold shadow limit; load=1 writes limit into it on the same edge.
REQ-015 SHALL copy shadow into active limit while en=0 and at every terminal event; never mid-period.
REQ-016 SHALL sample mode and prescale into internal registers only while en=0; changes while en=1 ignored.
REQ-017 SHALL run a prescale counter while en=1; tick asserted on the cycle it equals prescale_q, then clears; prescale_q=0 gives tick every cycle.
REQ-018 SHALL update count only on tick cycles; done pulses on the edge that applies the terminal action, exactly one cycle.
REQ-019 Mode 00: count+1 per tick; tick at count==active limit -> count=0, done=1.
REQ-020 Mode 01: count+1 per tick; tick at count==limit -> count holds at limit, done=1 once, busy=0 until en deasserted.
REQ-021 Mode 10: on en rise count=active limit, dir=1; count-1 per tick; tick at count==0 -> count=limit, done=1.
REQ-022 Mode 11: up to limit, then dir=1, down to 0, dir=0; done=1 only on the tick applying 0->up turnaround.
REQ-023 Turnaround SHALL not repeat endpoints: sequence for limit 2 is 0,1,2,1,0,1,2...
REQ-024 limit=0 SHALL give count constant 0 and done on every tick (modes 00,10,11); mode 01 done once.
REQ-025 en=0 SHALL force count=0, dir=0, done=0, busy=0, prescale counter 0 on next edge.
REQ-026 Arithmetic SHALL be WIDTH-bit unsigned; no wrap beyond limit; limit=2^WIDTH-1 legal.
REQ-027 load coincident with terminal tick SHALL make the new limit active for the following period.

Reset
REQ-028 rst_n_2 low SHALL asynchronously clear count, done, busy, dir, shadow/active limit, mode_q (00), prescale_q, prescale counter.
REQ-029 Reset mid-run SHALL abort immediately; after release block stays idle until en sampled high.

Structure
REQ-030 Shared package SHALL hold mode constants MODE_UPWRAP/ONESHOT/DOWNRELOAD/TRIANGLE and the 2-bit mode typedef.
REQ-031 Prescaler SHALL be sub-module cntr_prescaler (PRESCALE_W parameter, outputs tick).
REQ-032 All outputs SHALL be driven directly from flops.

Verification
REQ-033 Mode 00, limit=3, prescale=0, en=1 -> count 0,1,2,3,0; done high the cycle count returns to 0, period 4.
REQ-034 Mode 01, limit=5, prescale=1 -> count steps every 2 cycles to 5, one done pulse, busy=0, count holds 5.
REQ-035 Mode 11, limit=2 -> count 0,1,2,1,0,1; dir toggles at 2 and 0; done only at each return to 0.
REQ-036 Mode 10, limit=4, load limit=1 mid-period -> 4,3,2,1,0 then 1,0,1; done at each reload.
REQ-037 Assert rst_n_2 low mid-count at count=7 -> all outputs 0 same cycle, no done after release.
REQ-038 WIDTH=4, limit=15, mode 00 -> 0..15,0 with no overflow; limit=0 -> done every tick.

Source files
------------

// File: rtl/prog_cntr_timer_pkg.sv
// Shared mode encodings and run-state type for the programmable counter/timer.
package prog_cntr_timer_pkg;

    typedef enum logic [1:0] {
        MODE_UPWRAP     = 2'b00,
        MODE_ONESHOT    = 2'b01,
        MODE_DOWNRELOAD = 2'b10,
        MODE_TRIANGLE   = 2'b11
    } mode_e;

    // ST_IDLE covers the first enabled cycle, which seeds count/dir before any tick is honoured
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } run_state_e;

endpackage

// File: rtl/prog_cntr_timer_prescaler.sv
// Tick divider: asserts tick once every prescale_q+1 running cycles.
module cntr_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n_2,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale_q,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_cnt;

    assign tick = run && (div_cnt == prescale_q);

    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            div_cnt <= '0;
        end else if (!run || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_cntr_timer.sv
// Programmable counter/timer with up-wrap, one-shot, down-reload and triangle modes.
module prog_cntr_timer
    import prog_cntr_timer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n_2,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  done,
    output logic                  busy,
    output logic                  dir
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    run_state_e            state_q, state_n;
    mode_e                 mode_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [WIDTH-1:0]      shadow_q, shadow_n;
    logic [WIDTH-1:0]      active_q, active_n;
    logic [WIDTH-1:0]      count_n, cnt_inc, cnt_dec;
    logic                  dir_n, done_n, busy_n, term;
    logic                  tick;

    cntr_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n_2    (rst_n_2),
        .run        (en && (state_q == ST_RUN)),
        .prescale_q (prescale_q),
        .tick       (tick)
    );

    // Next-state and next-output decode; terminal events also retire the shadow limit
    always_comb begin
        shadow_n = load ? limit : shadow_q;
        cnt_inc  = count + ONE;
        cnt_dec  = count - ONE;
        state_n  = state_q;
        count_n  = count;
        dir_n    = dir;
        done_n   = 1'b0;
        term     = 1'b0;

        if (!en) begin
            state_n = ST_IDLE;
            count_n = '0;
            dir_n   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_n = ST_RUN;
                    if (mode_q == MODE_DOWNRELOAD) begin
                        count_n = active_q;
                        dir_n   = 1'b1;
                    end else begin
                        count_n = '0;
                        dir_n   = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        case (mode_q)
                            MODE_UPWRAP: begin
                                if (count >= active_q) begin
                                    count_n = '0;
                                    done_n  = 1'b1;
                                    term    = 1'b1;
                                end else begin
                                    count_n = cnt_inc;
                                end
                            end
                            MODE_ONESHOT: begin
                                if (count >= active_q) begin
                                    done_n  = 1'b1;
                                    term    = 1'b1;
                                    state_n = ST_HALT;
                                end else begin
                                    count_n = cnt_inc;
                                end
                            end
                            MODE_DOWNRELOAD: begin
                                if (count == '0) begin
                                    count_n = shadow_n;
                                    done_n  = 1'b1;
                                    term    = 1'b1;
                                end else begin
                                    count_n = cnt_dec;
                                end
                            end
                            MODE_TRIANGLE: begin
                                // Direction flips on arrival at an endpoint, so endpoints are never repeated
                                if (!dir) begin
                                    if (count >= active_q) begin
                                        count_n = '0;
                                        done_n  = 1'b1;
                                        term    = 1'b1;
                                    end else begin
                                        count_n = cnt_inc;
                                        dir_n   = (cnt_inc == active_q);
                                    end
                                end else begin
                                    if (count <= ONE) begin
                                        count_n = '0;
                                        dir_n   = 1'b0;
                                        done_n  = 1'b1;
                                        term    = 1'b1;
                                    end else begin
                                        count_n = cnt_dec;
                                    end
                                end
                            end
                            default: count_n = count;
                        endcase
                    end
                end
                ST_HALT: state_n = ST_HALT;
                default: state_n = ST_IDLE;
            endcase
        end

        busy_n   = (state_n == ST_RUN);
        active_n = (!en || term) ? shadow_n : active_q;
    end

    // Configuration is only sampled while stopped so a running period is never disturbed
    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_UPWRAP;
            prescale_q <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            count      <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            dir        <= 1'b0;
        end else begin
            state_q  <= state_n;
            shadow_q <= shadow_n;
            active_q <= active_n;
            count    <= count_n;
            done     <= done_n;
            busy     <= busy_n;
            dir      <= dir_n;
            if (!en) begin
                mode_q     <= mode_e'(mode);
                prescale_q <= prescale;
            end
        end
    end

endmodule

// File: tb/tb_prog_cntr_timer.sv
// Directed self-checking bench for prog_cntr_timer (WIDTH=8 and WIDTH=4 instances).
module tb_prog_cntr_timer;

    logic       clk = 1'b0;
    logic       rst_n_2;
    logic       en, load;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       done, busy, dir;

    logic       en4, load4;
    logic [1:0] mode4;
    logic [3:0] limit4, prescale4, count4;
    logic       done4, busy4, dir4;

    int checks = 0;
    int fails  = 0;

    int a_cnt [5]  = '{1, 2, 3, 0, 1};
    int a_done[5]  = '{0, 0, 0, 1, 0};
    int c_cnt [8]  = '{1, 2, 1, 0, 1, 2, 1, 0};
    int c_dir [8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    int c_done[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    int d_cnt [10] = '{3, 2, 1, 0, 1, 0, 2, 1, 0, 2};
    int d_done[10] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1};

    always #5 clk = ~clk;

    prog_cntr_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk(clk), .rst_n_2(rst_n_2), .en(en), .mode(mode), .limit(limit),
        .load(load), .prescale(prescale), .count(count), .done(done),
        .busy(busy), .dir(dir)
    );

    prog_cntr_timer #(.WIDTH(4), .PRESCALE_W(4)) dut4 (
        .clk(clk), .rst_n_2(rst_n_2), .en(en4), .mode(mode4), .limit(limit4),
        .load(load4), .prescale(prescale4), .count(count4), .done(done4),
        .busy(busy4), .dir(dir4)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [7:0] lim,
                                 input logic ld, input logic [3:0] ps);
        en = e; mode = m; limit = lim; load = ld; prescale = ps;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n_2 = 1'b0;
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 4'd0);
        en4 = 1'b0; mode4 = 2'b00; limit4 = 4'd0; load4 = 1'b0; prescale4 = 4'd0;
        step(2);
        checkOutput("reset count", count, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset dir", dir, 0);
        rst_n_2 = 1'b1;
        step(1);

        $display("[TB] up-wrap limit 3");
        applyStimulus(1'b0, 2'b00, 8'd3, 1'b1, 4'd0);
        step(1);
        applyStimulus(1'b1, 2'b00, 8'd3, 1'b0, 4'd0);
        step(1);
        checkOutput("A start count", count, 0);
        checkOutput("A start busy", busy, 1);
        applyStimulus(1'b1, 2'b11, 8'd3, 1'b0, 4'd3);
        for (int k = 0; k < 5; k++) begin
            step(1);
            checkOutput($sformatf("A count %0d", k), count, a_cnt[k]);
            checkOutput($sformatf("A done %0d", k), done, a_done[k]);
            checkOutput($sformatf("A dir %0d", k), dir, 0);
        end
        applyStimulus(1'b0, 2'b00, 8'd3, 1'b0, 4'd0);
        step(1);
        checkOutput("A stop count", count, 0);
        checkOutput("A stop busy", busy, 0);

        $display("[TB] one-shot limit 5 prescale 1");
        applyStimulus(1'b0, 2'b01, 8'd5, 1'b1, 4'd1);
        step(1);
        applyStimulus(1'b1, 2'b01, 8'd5, 1'b0, 4'd1);
        step(1);
        checkOutput("B start busy", busy, 1);
        for (int k = 1; k <= 14; k++) begin
            step(1);
            checkOutput($sformatf("B count %0d", k), count, (k / 2 > 5) ? 5 : k / 2);
            checkOutput($sformatf("B done %0d", k), done, (k == 12) ? 1 : 0);
            checkOutput($sformatf("B busy %0d", k), busy, (k < 12) ? 1 : 0);
        end
        applyStimulus(1'b0, 2'b01, 8'd5, 1'b0, 4'd1);
        step(1);

        $display("[TB] triangle limit 2");
        applyStimulus(1'b0, 2'b11, 8'd2, 1'b1, 4'd0);
        step(1);
        applyStimulus(1'b1, 2'b11, 8'd2, 1'b0, 4'd0);
        step(1);
        checkOutput("C start count", count, 0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            checkOutput($sformatf("C count %0d", k), count, c_cnt[k]);
            checkOutput($sformatf("C dir %0d", k), dir, c_dir[k]);
            checkOutput($sformatf("C done %0d", k), done, c_done[k]);
        end
        applyStimulus(1'b0, 2'b11, 8'd2, 1'b0, 4'd0);
        step(1);

        $display("[TB] down-reload limit 4 with reloads");
        applyStimulus(1'b0, 2'b10, 8'd4, 1'b1, 4'd0);
        step(1);
        applyStimulus(1'b1, 2'b10, 8'd4, 1'b0, 4'd0);
        step(1);
        checkOutput("D start count", count, 4);
        checkOutput("D start dir", dir, 1);
        for (int k = 0; k < 10; k++) begin
            step(1);
            checkOutput($sformatf("D count %0d", k), count, d_cnt[k]);
            checkOutput($sformatf("D done %0d", k), done, d_done[k]);
            checkOutput($sformatf("D dir %0d", k), dir, 1);
            if (k == 0)      applyStimulus(1'b1, 2'b10, 8'd1, 1'b1, 4'd0);
            else if (k == 5) applyStimulus(1'b1, 2'b10, 8'd2, 1'b1, 4'd0);
            else             applyStimulus(1'b1, 2'b10, 8'd0, 1'b0, 4'd0);
        end
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 4'd0);
        step(1);

        $display("[TB] reset mid-count");
        applyStimulus(1'b0, 2'b00, 8'd20, 1'b1, 4'd0);
        step(1);
        applyStimulus(1'b1, 2'b00, 8'd20, 1'b0, 4'd0);
        step(1);
        step(7);
        checkOutput("E count before reset", count, 7);
        checkOutput("E busy before reset", busy, 1);
        #2 rst_n_2 = 1'b0;
        #1;
        checkOutput("E reset count", count, 0);
        checkOutput("E reset busy", busy, 0);
        checkOutput("E reset done", done, 0);
        checkOutput("E reset dir", dir, 0);
        applyStimulus(1'b0, 2'b00, 8'd20, 1'b0, 4'd0);
        step(2);
        rst_n_2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checkOutput($sformatf("E idle done %0d", k), done, 0);
            checkOutput($sformatf("E idle count %0d", k), count, 0);
        end

        $display("[TB] limit 0");
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b1, 4'd0);
        step(1);
        applyStimulus(1'b1, 2'b00, 8'd0, 1'b0, 4'd0);
        step(1);
        for (int k = 0; k < 3; k++) begin
            step(1);
            checkOutput($sformatf("F upwrap done %0d", k), done, 1);
            checkOutput($sformatf("F upwrap count %0d", k), count, 0);
        end
        applyStimulus(1'b0, 2'b01, 8'd0, 1'b0, 4'd0);
        step(1);
        applyStimulus(1'b1, 2'b01, 8'd0, 1'b0, 4'd0);
        step(1);
        step(1);
        checkOutput("F oneshot done", done, 1);
        checkOutput("F oneshot busy", busy, 0);
        step(1);
        checkOutput("F oneshot done once", done, 0);
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 4'd0);
        step(1);

        $display("[TB] WIDTH=4 full range");
        en4 = 1'b0; mode4 = 2'b00; limit4 = 4'd15; load4 = 1'b1; prescale4 = 4'd0;
        step(1);
        en4 = 1'b1; load4 = 1'b0;
        step(1);
        checkOutput("G start count", count4, 0);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            checkOutput($sformatf("G count %0d", k), count4, k % 16);
            checkOutput($sformatf("G done %0d", k), done4, (k == 16) ? 1 : 0);
        end
        en4 = 1'b0; limit4 = 4'd0; load4 = 1'b1;
        step(1);
        en4 = 1'b1; load4 = 1'b0;
        step(1);
        for (int k = 0; k < 3; k++) begin
            step(1);
            checkOutput($sformatf("G zero done %0d", k), done4, 1);
            checkOutput($sformatf("G zero count %0d", k), count4, 0);
        end
        en4 = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
